// File: rtl/integration3_cpu.sv
// integration3_cpu: multicycle 16-bit accumulator CPU with a unified 1024x16 memory.
// Memory has no reset and is loaded externally before reset is released.
module integration3_cpu (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] FPGAIn,
    output logic [15:0] FPGAOut,
    output logic [15:0] IROutBranch,
    output logic [15:0] PCOutTest,
    output logic [15:0] ACCTest,
    output logic [15:0] SPTest,
    output logic [15:0] MemoutTest,
    output logic [15:0] DataOut,
    output logic [15:0] MeminTest,
    output logic [15:0] InTest,
    output logic [15:0] ALUDirectOutTest,
    output logic [15:0] ALUOutTest,
    output logic        PCWriteTest,
    output logic        IRWriteTest,
    output logic        MemWriteTest,
    output logic [1:0]  MemAddrTest,
    output logic        AluZeroTest,
    output logic        ALUovflTest
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, EXEC2, WB2} stateType;

    localparam logic [4:0] opLw = 5'h00, opSw = 5'h01, opAdd = 5'h02, opSub = 5'h03,
                           opOr = 5'h04, opAnd = 5'h05, opLi = 5'h06, opSpi = 5'h07,
                           opSpc = 5'h08, opLwa = 5'h09, opIn = 5'h0A, opOut = 5'h0B,
                           opBeq = 5'h0C, opJ = 5'h0D;

    stateType state, nextState;
    logic [15:0] pc, acc, sp, ir, mdr, aluOut, fpgaOut, inReg;
    logic [15:0] mem [0:1023];
    logic [15:0] sext, memout, pcNext, aluA, aluB, aluSum, aluY;
    logic [9:0]  memIdx;
    logic [4:0]  op;
    logic [1:0]  memAddr;
    logic        pcWrite, irWrite, memWrite, isAluMem, isAdd, isSub;

    assign op       = ir[15:11];
    assign sext     = {{5{ir[10]}}, ir[10:0]};
    assign isAluMem = op inside {opLw, opAdd, opSub, opOr, opAnd};
    assign isSub    = op == opSub;
    assign isAdd    = op inside {opAdd, opBeq, opSpi, opSpc};

    // Only 10 address bits index the memory; the rest of each source is ignored.
    assign memIdx = memAddr == 2'd0 ? pc[9:0] :
                    memAddr == 2'd1 ? sext[9:0] :
                    memAddr == 2'd2 ? sp[9:0] : acc[9:0];
    assign memout = mem[memIdx];

    // The ALU doubles as the address adder for branches and stack moves.
    assign aluA   = op == opBeq ? pc : (op == opSpi || op == opSpc) ? sp : acc;
    assign aluB   = op inside {opBeq, opSpi, opSpc} ? sext : mdr;
    assign aluSum = aluA + (isSub ? ~aluB : aluB) + {15'd0, isSub};
    assign aluY   = (isAdd || isSub) ? aluSum :
                    op == opOr ? aluA | aluB :
                    op == opAnd ? aluA & aluB : aluB;

    always_comb begin
        nextState = FETCH;
        pcWrite   = 1'b0;
        irWrite   = 1'b0;
        memWrite  = 1'b0;
        memAddr   = 2'd0;
        pcNext    = pc + 16'd1;
        case (state)
            FETCH: begin
                pcWrite   = 1'b1;
                irWrite   = 1'b1;
                nextState = DECODE;
            end
            DECODE: begin
                memAddr   = op == opLwa ? 2'd3 : op == opSpc ? 2'd2 : (isAluMem || op == opSw) ? 2'd1 : 2'd0;
                nextState = EXEC;
            end
            EXEC: begin
                pcWrite   = op == opJ || (op == opBeq && acc == 16'd0);
                pcNext    = op == opJ ? sext : aluY;
                nextState = op == opSw ? MEM : (isAluMem || op == opLwa) ? WB : op == opSpc ? EXEC2 : FETCH;
            end
            MEM: begin
                memWrite = 1'b1;
                memAddr  = 2'd1;
            end
            EXEC2: begin
                memAddr   = 2'd2;
                nextState = WB2;
            end
            default: nextState = FETCH;
        endcase
        if (!reset) begin
            pcWrite  = 1'b0;
            irWrite  = 1'b0;
            memWrite = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            pc      <= '0;
            acc     <= '0;
            sp      <= '0;
            ir      <= '0;
            mdr     <= '0;
            aluOut  <= '0;
            fpgaOut <= '0;
            inReg   <= '0;
        end else begin
            state <= nextState;
            inReg <= FPGAIn;
            if (pcWrite) pc <= pcNext;
            if (irWrite) ir <= memout;
            if (state == DECODE || state == EXEC2) mdr <= memout;
            if (state == EXEC) aluOut <= aluY;
            if (state == EXEC && (op == opSpi || op == opSpc)) sp <= aluY;
            if (state == EXEC && op == opOut) fpgaOut <= acc;
            if (state == WB) acc <= aluOut;
            else if (state == WB2) acc <= mdr;
            else if (state == EXEC && op == opLi) acc <= sext;
            else if (state == EXEC && op == opIn) acc <= inReg;
        end
    end

    always_ff @(posedge CLK) begin
        if (memWrite) mem[memIdx] <= acc;
    end

    assign FPGAOut          = fpgaOut;
    assign IROutBranch      = ir;
    assign PCOutTest        = pc;
    assign ACCTest          = acc;
    assign SPTest           = sp;
    assign MemoutTest       = memout;
    assign DataOut          = mdr;
    assign MeminTest        = acc;
    assign InTest           = inReg;
    assign ALUDirectOutTest = aluY;
    assign ALUOutTest       = aluOut;
    assign PCWriteTest      = pcWrite;
    assign IRWriteTest      = irWrite;
    assign MemWriteTest     = memWrite;
    assign MemAddrTest      = memAddr;
    assign AluZeroTest      = aluY == 16'd0;
    assign ALUovflTest      = (isAdd && aluA[15] == aluB[15] && aluY[15] != aluA[15]) ||
                              (isSub && aluA[15] != aluB[15] && aluY[15] != aluA[15]);
endmodule

// File: tb/tb_integration3_cpu.sv
// tb_integration3_cpu: directed program run on integration3_cpu with hand-computed results.
module tb_integration3_cpu;
    logic CLK = 1'b0, reset = 1'b0;
    logic [15:0] FPGAIn = 16'h0000;
    logic [15:0] FPGAOut, IROutBranch, PCOutTest, ACCTest, SPTest, MemoutTest, DataOut;
    logic [15:0] MeminTest, InTest, ALUDirectOutTest, ALUOutTest;
    logic PCWriteTest, IRWriteTest, MemWriteTest, AluZeroTest, ALUovflTest;
    logic [1:0] MemAddrTest;
    int total = 0, bad = 0;

    integration3_cpu dut (
        .CLK(CLK), .reset(reset), .FPGAIn(FPGAIn), .FPGAOut(FPGAOut),
        .IROutBranch(IROutBranch), .PCOutTest(PCOutTest), .ACCTest(ACCTest),
        .SPTest(SPTest), .MemoutTest(MemoutTest), .DataOut(DataOut),
        .MeminTest(MeminTest), .InTest(InTest), .ALUDirectOutTest(ALUDirectOutTest),
        .ALUOutTest(ALUOutTest), .PCWriteTest(PCWriteTest), .IRWriteTest(IRWriteTest),
        .MemWriteTest(MemWriteTest), .MemAddrTest(MemAddrTest),
        .AluZeroTest(AluZeroTest), .ALUovflTest(ALUovflTest)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) dut.mem[i] = 16'h0000;
        dut.mem[10'h00] = 16'h0020; dut.mem[10'h01] = 16'h1021; dut.mem[10'h02] = 16'h1821;
        dut.mem[10'h03] = 16'h2021; dut.mem[10'h04] = 16'h2821; dut.mem[10'h05] = 16'h3FFC;
        dut.mem[10'h06] = 16'h47FE; dut.mem[10'h07] = 16'h3030; dut.mem[10'h08] = 16'h4800;
        dut.mem[10'h09] = 16'h37FF; dut.mem[10'h0A] = 16'h1021; dut.mem[10'h0B] = 16'h0022;
        dut.mem[10'h0C] = 16'h1021; dut.mem[10'h0D] = 16'h1821; dut.mem[10'h0E] = 16'h5000;
        dut.mem[10'h0F] = 16'h5800; dut.mem[10'h10] = 16'h6002; dut.mem[10'h11] = 16'h3000;
        dut.mem[10'h12] = 16'h6003; dut.mem[10'h16] = 16'h6840; dut.mem[10'h40] = 16'h3005;
        dut.mem[10'h41] = 16'h0851; dut.mem[10'h42] = 16'h0850;
        dut.mem[10'h20] = 16'h0002; dut.mem[10'h21] = 16'h0001; dut.mem[10'h22] = 16'h7FFF;
        dut.mem[10'h30] = 16'h0101; dut.mem[10'h3FA] = 16'h0002; dut.mem[10'h50] = 16'hBEEF;
        FPGAIn = 16'h00A5;
        step(2);
        check("rst_pc", PCOutTest, 16'h0000);
        check("rst_acc", ACCTest, 16'h0000);
        check("rst_sp", SPTest, 16'h0000);
        check("rst_ir", IROutBranch, 16'h0000);
        check("rst_in", InTest, 16'h0000);
        check("rst_out", FPGAOut, 16'h0000);
        check("rst_we", {13'd0, PCWriteTest, IRWriteTest, MemWriteTest}, 16'h0000);
        reset = 1'b1;
        step(1);
        check("fetch_ir", IROutBranch, 16'h0020);
        check("fetch_pc", PCOutTest, 16'h0001);
        check("in_reg", InTest, 16'h00A5);
        step(3);
        check("lw_acc", ACCTest, 16'h0002);
        check("lw_pc", PCOutTest, 16'h0001);
        step(4); check("add_acc", ACCTest, 16'h0003);
        step(4); check("sub_acc", ACCTest, 16'h0002);
        step(4); check("or_acc", ACCTest, 16'h0003);
        step(4); check("and_acc", ACCTest, 16'h0001);
        step(3);
        check("spi_sp", SPTest, 16'hFFFC);
        check("spi_acc", ACCTest, 16'h0001);
        step(5);
        check("spc_sp", SPTest, 16'hFFFA);
        check("spc_acc", ACCTest, 16'h0002);
        check("spc_pc", PCOutTest, 16'h0007);
        step(3); check("li_acc", ACCTest, 16'h0030);
        step(4); check("lwa_acc", ACCTest, 16'h0101);
        step(3); check("li_neg", ACCTest, 16'hFFFF);
        step(3);
        check("wrap_alu", ALUDirectOutTest, 16'h0000);
        check("wrap_zero", 16'(AluZeroTest), 16'h0001);
        check("wrap_ovfl", 16'(ALUovflTest), 16'h0000);
        check("wrap_aluout", ALUOutTest, 16'h0000);
        step(1); check("wrap_acc", ACCTest, 16'h0000);
        step(4); check("lw_max", ACCTest, 16'h7FFF);
        step(3);
        check("ovf_add_alu", ALUDirectOutTest, 16'h8000);
        check("ovf_add", 16'(ALUovflTest), 16'h0001);
        check("ovf_zero", 16'(AluZeroTest), 16'h0000);
        step(1); check("ovf_add_acc", ACCTest, 16'h8000);
        step(3);
        check("ovf_sub_alu", ALUDirectOutTest, 16'h7FFF);
        check("ovf_sub", 16'(ALUovflTest), 16'h0001);
        step(1);
        step(3); check("in_acc", ACCTest, 16'h00A5);
        step(3); check("out_reg", FPGAOut, 16'h00A5);
        step(3); check("beq_nt_pc", PCOutTest, 16'h0011);
        step(3); check("li_zero", ACCTest, 16'h0000);
        step(3); check("beq_t_pc", PCOutTest, 16'h0016);
        step(3); check("j_pc", PCOutTest, 16'h0040);
        step(3); check("li5", ACCTest, 16'h0005);
        step(3);
        check("sw_we", 16'(MemWriteTest), 16'h0001);
        check("sw_sel", 16'(MemAddrTest), 16'h0001);
        check("sw_data", MeminTest, 16'h0005);
        step(1);
        check("sw_mem", dut.mem[10'h51], 16'h0005);
        check("sw_pc", PCOutTest, 16'h0042);
        step(2);
        check("abort_we", 16'(MemWriteTest), 16'h0000);
        #2 reset = 1'b0;
        #1;
        check("abort_pc", PCOutTest, 16'h0000);
        check("abort_sp", SPTest, 16'h0000);
        check("abort_acc", ACCTest, 16'h0000);
        step(1);
        check("abort_mem", dut.mem[10'h50], 16'hBEEF);
        reset = 1'b1;
        step(4);
        check("restart_acc", ACCTest, 16'h0002);
        check("restart_pc", PCOutTest, 16'h0001);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
